psr_stack: RTL and testbench
============================

# psr_stack

Parametrised processor status register with per-flag update masking, direct bus load and a LIFO save/restore stack for interrupt entry and return. It sits after the ALU result register in the datapath and replaces the fixed 12-bit, five-flag status register. It adds a signed-overflow flag, a correct zero flag and flag preservation across nested interrupts/calls.

## Interface
Parameters:
- Bits, 12, ALU result width; iData carries Bits+1 bits (MSB = carry out)
- Depth, 4, save stack entries (>= 1)

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  reset; asynchronous, active-low
- iData  in  Bits+1  ALU result; iData[Bits] = carry out
- iOvf  in  1  ALU signed overflow
- iUpd  in  1  update flags from iData/iOvf
- iMask  in  6  per-flag update enable, same bit order as oPSR
- iLoad  in  1  write oPSR from iLoadData (bus write / software restore)
- iLoadData  in  6  value for iLoad
- iPush  in  1  save current oPSR on stack
- iPop  in  1  restore oPSR from stack top
- iClrErr  in  1  clear sticky oErr
- oPSR  out  6  [0]C carry, [1]E even, [2]P odd parity, [3]Z zero, [4]N negative, [5]V overflow
- oDepth  out  $clog2(Depth+1)  occupied stack entries
- oFull  out  1  oDepth == Depth
- oEmpty  out  1  oDepth == 0
- oErr  out  1  sticky: push on full or pop on empty

## Operation
- Flag computation, combinational from iData, with R = iData[Bits-1:0]:
  - C = iData[Bits]
  - E = ~R[0]
  - P = ^R (carry excluded)
  - Z = ~|R (NOR reduction)
  - N = R[Bits-1]
  - V = iOvf
- Live register next-state priority, highest first:
  1. Valid pop (iPop & ~iPush & ~oEmpty): oPSR <= stack top.
  2. iLoad: oPSR <= iLoadData.
  3. iUpd: oPSR[i] <= new flag i where iMask[i]=1; flags with iMask[i]=0 hold.
  4. Otherwise: hold.
- Push (iPush & ~iPop):
  - Not full: writes the pre-edge oPSR at index oDepth; oDepth+1.
  - Full: no write, oDepth holds, oErr <= 1.
  - A push does not block iLoad/iUpd in the same cycle. This is the interrupt-entry sequence: save old flags and load new ones in one cycle.
- Pop (iPop & ~iPush):
  - Not empty: oDepth-1; the popped value goes to oPSR; iLoad/iUpd in the same cycle are discarded.
  - Empty: oPSR unaffected by the pop (iLoad/iUpd apply normally), oErr <= 1.
- iPush & iPop in the same cycle: stack and oErr unchanged; iLoad/iUpd apply normally.
- oErr is cleared by iClrErr unless a new error occurs in the same cycle, in which case it stays 1.
- Stack contents are not cleared on reset; only the pointer is. Entries at index >= oDepth are don't-care.

## Timing
- Reset (asynchronous, immediate on iRst_n low, including mid-operation): oPSR = 6'b0, oDepth = 0, oEmpty = 1, oFull = 0, oErr = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Update, load, push and pop all have 1-cycle latency: the effect is visible after the next rising iClk.
- oFull, oEmpty and oDepth change on the same edge as the pointer.
- Back-to-back push/pop on every cycle is supported with no bubbles.

## Structure
- Shared package psr_pkg holds:
  - Flag index constants: FLAG_C=0, FLAG_E=1, FLAG_P=2, FLAG_Z=3, FLAG_N=4, FLAG_V=5.
  - NUM_FLAGS=6.
  - A psr_t typedef of NUM_FLAGS bits.
- One sub-module, psr_flag_stack, holds the Depth x NUM_FLAGS LIFO storage, the pointer, full/empty decode and error detection.
- The top level keeps the flag logic, mask merge and priority mux.

## Test plan
All scenarios use Bits=12, Depth=4.
- Reset: drive iRst_n=0 between clock edges after pushing 2 entries and loading 6'h3F → oPSR=0, oDepth=0, oEmpty=1, oErr=0 immediately, without a clock edge.
- Full update: iUpd=1, iMask=6'h3F, iData=13'h1000, iOvf=0 → next cycle oPSR=6'h0B (C=1, E=1, Z=1). Then iData=13'h0801, iOvf=1 → oPSR=6'h30 (N, V set; P=0 with two ones in R).
- Masked update: from oPSR=6'h0B, iUpd=1, iMask=6'h01, iData=13'h0800 → oPSR=6'h0A; only C changes.
- Stack fill/drain: load 6'h01, 6'h02, 6'h04, 6'h08, pushing after each load.
  - After the 4th push: oFull=1, oDepth=4.
  - 5th push → oErr=1, oDepth stays 4.
  - Four pops → oPSR=6'h08, 6'h04, 6'h02, 6'h01, then oEmpty=1.
  - 6th pop → oErr stays 1; iClrErr → oErr=0.
- Interrupt entry: oPSR=6'h15; iPush with iLoad of 6'h00 in the same cycle → stack top=6'h15, oPSR=6'h00. Then iPop with iUpd (iData=13'h0000, iMask=6'h3F) in the same cycle → oPSR=6'h15; the update is discarded.
- Simultaneous push+pop at oDepth=2 with iUpd, iMask=6'h3F, iData=13'h0000 → oDepth stays 2, oErr=0, oPSR=6'h0A.

Source files
------------

// File: rtl/psr_pkg.sv
// psr_pkg
// Shared definitions for the processor status register slice.
// Holds the flag bit positions inside the status word, the flag count and
// the status word type used by the interface, the stack and the top level.
package psr_pkg;

  localparam int NUM_FLAGS = 6;

  localparam int FLAG_C = 0;
  localparam int FLAG_E = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  localparam int FLAG_V = 5;

  typedef logic [NUM_FLAGS-1:0] psr_t;

endpackage

// File: rtl/psr_stack_if.sv
// psr_stack_if
// Bundles the datapath/control side of the status register.
//   iData/iOvf/iUpd/iMask : ALU result, overflow, update strobe, flag enables
//   iLoad/iLoadData       : direct bus write of the whole status word
//   iPush/iPop            : save/restore on the flag stack
//   iClrErr               : clear the sticky stack error
//   oPSR/oDepth/oFull/oEmpty/oErr : registered status and stack state
// master drives the controls (datapath/bench), slave is the status register.
interface psr_stack_if #(
  parameter int Bits  = 12,
  parameter int Depth = 4
);
  import psr_pkg::*;

  localparam int DepthW = $clog2(Depth + 1);

  logic [Bits:0]     iData;
  logic              iOvf;
  logic              iUpd;
  psr_t              iMask;
  logic              iLoad;
  psr_t              iLoadData;
  logic              iPush;
  logic              iPop;
  logic              iClrErr;

  psr_t              oPSR;
  logic [DepthW-1:0] oDepth;
  logic              oFull;
  logic              oEmpty;
  logic              oErr;

  modport master (
    output iData, iOvf, iUpd, iMask, iLoad, iLoadData, iPush, iPop, iClrErr,
    input  oPSR, oDepth, oFull, oEmpty, oErr
  );

  modport slave (
    input  iData, iOvf, iUpd, iMask, iLoad, iLoadData, iPush, iPop, iClrErr,
    output oPSR, oDepth, oFull, oEmpty, oErr
  );

endinterface

// File: rtl/psr_flag_stack.sv
// psr_flag_stack
// LIFO of saved status words used across interrupt entry/return.
//   iClk, iRst_n : clock, asynchronous active-low reset (pointer only)
//   iPush, iPop  : save / restore request; both at once is a no-op
//   iClrErr      : clear sticky error
//   iWrData      : status word to save
//   oTop         : entry at the top of the stack (valid when not empty)
//   oPopValid    : a restore takes effect on this edge
//   oDepth, oFull, oEmpty, oErr : occupancy and sticky misuse flag
module psr_flag_stack
  import psr_pkg::*;
#(
  parameter int Depth = 4,
  parameter int PtrW  = $clog2(Depth + 1)
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic            iPush,
  input  logic            iPop,
  input  logic            iClrErr,
  input  psr_t            iWrData,
  output psr_t            oTop,
  output logic            oPopValid,
  output logic [PtrW-1:0] oDepth,
  output logic            oFull,
  output logic            oEmpty,
  output logic            oErr
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  psr_t            mem [Depth];
  logic [PtrW-1:0] ptr;
  logic            errReg;
  logic            pushOnly;
  logic            popOnly;
  logic            doPush;
  logic            doPop;
  logic            errNow;
  logic [IdxW-1:0] wrIdx;
  logic [IdxW-1:0] rdIdx;

  assign oFull    = (ptr == PtrW'(Depth));
  assign oEmpty   = (ptr == '0);
  assign pushOnly = iPush & ~iPop;
  assign popOnly  = iPop & ~iPush;
  assign doPush   = pushOnly & ~oFull;
  assign doPop    = popOnly & ~oEmpty;
  assign errNow   = (pushOnly & oFull) | (popOnly & oEmpty);

  // Pointer counts occupied entries; the next free slot is at ptr and the
  // top of stack at ptr-1, truncated to the storage index width.
  assign wrIdx = IdxW'(ptr);
  assign rdIdx = IdxW'(ptr - 1'b1);

  assign oTop      = mem[rdIdx];
  assign oPopValid = doPop;
  assign oDepth    = ptr;
  assign oErr      = errReg;

  // Storage is deliberately left out of reset; entries above the pointer
  // are never observed.
  always_ff @(posedge iClk) begin
    if (doPush) begin
      mem[wrIdx] <= iWrData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr <= '0;
    end else if (doPush) begin
      ptr <= ptr + 1'b1;
    end else if (doPop) begin
      ptr <= ptr - 1'b1;
    end
  end

  // A fresh error wins over a clear issued in the same cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      errReg <= 1'b0;
    end else if (errNow) begin
      errReg <= 1'b1;
    end else if (iClrErr) begin
      errReg <= 1'b0;
    end
  end

endmodule

// File: rtl/psr_stack.sv
// psr_stack
// Processor status register with per-flag masked update from the ALU
// result, direct bus load and a save/restore stack for nested interrupts.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   bus          : psr_stack_if slave (controls in, status/stack state out)
// Flags: [0]C carry, [1]E even, [2]P odd parity, [3]Z zero, [4]N negative,
// [5]V signed overflow.
module psr_stack
  import psr_pkg::*;
#(
  parameter int Bits  = 12,
  parameter int Depth = 4
) (
  input logic        iClk,
  input logic        iRst_n,
  psr_stack_if.slave bus
);

  logic [Bits-1:0] result;
  psr_t            newFlags;
  psr_t            merged;
  psr_t            psrReg;
  psr_t            stackTop;
  logic            popValid;

  assign result = bus.iData[Bits-1:0];

  // Carry is kept out of the parity, zero and sign decisions.
  always_comb begin
    newFlags         = '0;
    newFlags[FLAG_C] = bus.iData[Bits];
    newFlags[FLAG_E] = ~result[0];
    newFlags[FLAG_P] = ^result;
    newFlags[FLAG_Z] = ~|result;
    newFlags[FLAG_N] = result[Bits-1];
    newFlags[FLAG_V] = bus.iOvf;
  end

  assign merged = (psrReg & ~bus.iMask) | (newFlags & bus.iMask);

  psr_flag_stack #(
    .Depth (Depth)
  ) uStack (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iPush     (bus.iPush),
    .iPop      (bus.iPop),
    .iClrErr   (bus.iClrErr),
    .iWrData   (psrReg),
    .oTop      (stackTop),
    .oPopValid (popValid),
    .oDepth    (bus.oDepth),
    .oFull     (bus.oFull),
    .oEmpty    (bus.oEmpty),
    .oErr      (bus.oErr)
  );

  // A successful restore overrides any load or update in the same cycle, so
  // an interrupt return always gets back exactly the saved flags. A push
  // saves the pre-edge value and leaves load/update free to act.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      psrReg <= '0;
    end else if (popValid) begin
      psrReg <= stackTop;
    end else if (bus.iLoad) begin
      psrReg <= bus.iLoadData;
    end else if (bus.iUpd) begin
      psrReg <= merged;
    end
  end

  assign bus.oPSR = psrReg;

endmodule

// File: tb/tb_psr_stack.sv
// tb_psr_stack
// Directed scoreboard bench for psr_stack (Bits=12, Depth=4).
// Stimulus queues the hand-computed status expected after each clock edge;
// an independent monitor pops and compares once that edge has happened.
module tb_psr_stack;
  import psr_pkg::*;

  localparam int Bits  = 12;
  localparam int Depth = 4;

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  step;
    psr_t        psr;
    logic [2:0]  depth;
    logic        err;
  } exp_t;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b1;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;
  int   stepNo      = 0;
  event asyncCheck;

  psr_stack_if #(.Bits(Bits), .Depth(Depth)) bus();

  psr_stack #(.Bits(Bits), .Depth(Depth)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  // Free-running clock and an edge counter used to time-stamp expectations.
  always #5 iClk = ~iClk;

  always @(posedge iClk) cycleCount <= cycleCount + 1;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  // Compare every visible status output against one expectation.
  task automatic checkOutput(input exp_t e);
    logic expFull;
    logic expEmpty;
    expFull  = (e.depth == 3'(Depth));
    expEmpty = (e.depth == 3'd0);
    testsRun++;
    if (bus.oPSR !== e.psr) begin
      testsFailed++;
      $display("[TB] FAIL step%0d psr: got %h expected %h", e.step, bus.oPSR, e.psr);
    end
    testsRun++;
    if (bus.oDepth !== e.depth) begin
      testsFailed++;
      $display("[TB] FAIL step%0d depth: got %0d expected %0d", e.step, bus.oDepth, e.depth);
    end
    testsRun++;
    if (bus.oFull !== expFull) begin
      testsFailed++;
      $display("[TB] FAIL step%0d full: got %b expected %b", e.step, bus.oFull, expFull);
    end
    testsRun++;
    if (bus.oEmpty !== expEmpty) begin
      testsFailed++;
      $display("[TB] FAIL step%0d empty: got %b expected %b", e.step, bus.oEmpty, expEmpty);
    end
    testsRun++;
    if (bus.oErr !== e.err) begin
      testsFailed++;
      $display("[TB] FAIL step%0d err: got %b expected %b", e.step, bus.oErr, e.err);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge (away from the active
  // edge), or on demand for the asynchronous reset check.
  initial begin
    forever begin
      @(negedge iClk or asyncCheck);
      while (expQ.size() > 0 && expQ[0].due <= 32'(cycleCount)) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Drive one cycle of controls just after a rising edge and queue what the
  // status must look like after the following edge.
  task automatic applyStimulus(
    input logic        upd,
    input psr_t        mask,
    input logic [Bits:0] data,
    input logic        ovf,
    input logic        load,
    input psr_t        ldData,
    input logic        push,
    input logic        pop,
    input logic        clr,
    input psr_t        expPsr,
    input logic [2:0]  expDepth,
    input logic        expErr
  );
    exp_t e;
    @(posedge iClk);
    #1;
    bus.iUpd      = upd;
    bus.iMask     = mask;
    bus.iData     = data;
    bus.iOvf      = ovf;
    bus.iLoad     = load;
    bus.iLoadData = ldData;
    bus.iPush     = push;
    bus.iPop      = pop;
    bus.iClrErr   = clr;
    stepNo++;
    e.due   = 32'(cycleCount + 1);
    e.step  = 8'(stepNo);
    e.psr   = expPsr;
    e.depth = expDepth;
    e.err   = expErr;
    expQ.push_back(e);
  endtask

  // Queue an immediate expectation and wake the monitor without a clock.
  task automatic queueAsync(input psr_t expPsr, input logic [2:0] expDepth, input logic expErr);
    exp_t e;
    stepNo++;
    e.due   = 32'(cycleCount);
    e.step  = 8'(stepNo);
    e.psr   = expPsr;
    e.depth = expDepth;
    e.err   = expErr;
    expQ.push_back(e);
    #1;
    ->asyncCheck;
  endtask

  initial begin
    bus.iUpd      = 1'b0;
    bus.iMask     = '0;
    bus.iData     = '0;
    bus.iOvf      = 1'b0;
    bus.iLoad     = 1'b0;
    bus.iLoadData = '0;
    bus.iPush     = 1'b0;
    bus.iPop      = 1'b0;
    bus.iClrErr   = 1'b0;

    // Power-on reset, checked between edges while still asserted.
    #2 iRst_n = 1'b0;
    #10;
    queueAsync(6'h00, 3'd0, 1'b0);
    @(negedge iClk);
    #1 iRst_n = 1'b1;

    // Flag computation and masking.
    applyStimulus(1, 6'h3F, 13'h1000, 1, 0, 6'h00, 0, 0, 0, 6'h2B, 3'd0, 0);
    applyStimulus(1, 6'h3F, 13'h1000, 0, 0, 6'h00, 0, 0, 0, 6'h0B, 3'd0, 0);
    applyStimulus(1, 6'h3F, 13'h0801, 1, 0, 6'h00, 0, 0, 0, 6'h30, 3'd0, 0);
    applyStimulus(1, 6'h3F, 13'h0007, 0, 0, 6'h00, 0, 0, 0, 6'h04, 3'd0, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h0B, 0, 0, 0, 6'h0B, 3'd0, 0);
    applyStimulus(1, 6'h01, 13'h0800, 0, 0, 6'h00, 0, 0, 0, 6'h0A, 3'd0, 0);
    applyStimulus(0, 6'h3F, 13'h1FFF, 1, 0, 6'h00, 0, 0, 0, 6'h0A, 3'd0, 0);

    // Fill the stack.
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h01, 0, 0, 0, 6'h01, 3'd0, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h01, 3'd1, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h02, 0, 0, 0, 6'h02, 3'd1, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h02, 3'd2, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h04, 0, 0, 0, 6'h04, 3'd2, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h04, 3'd3, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h08, 0, 0, 0, 6'h08, 3'd3, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h08, 3'd4, 0);
    // Push on full.
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h08, 3'd4, 1);

    // Drain, then pop on empty (load still applies), then clear.
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h08, 3'd3, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h04, 3'd2, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h02, 3'd1, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h01, 3'd0, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h2A, 0, 1, 0, 6'h2A, 3'd0, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 0, 1, 6'h2A, 3'd0, 0);
    // New error in the same cycle as a clear keeps the error.
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 1, 6'h2A, 3'd0, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 0, 1, 6'h2A, 3'd0, 0);

    // Interrupt entry (save + load) and return (restore beats update).
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h15, 0, 0, 0, 6'h15, 3'd0, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h00, 1, 0, 0, 6'h00, 3'd1, 0);
    applyStimulus(1, 6'h3F, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h15, 3'd0, 0);

    // Simultaneous push and pop at depth 2: stack idle, update applies.
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h15, 3'd1, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h15, 3'd2, 0);
    applyStimulus(1, 6'h3F, 13'h0000, 0, 0, 6'h00, 1, 1, 0, 6'h0A, 3'd2, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h15, 3'd1, 0);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h15, 3'd0, 0);

    // Build up state (error set, two entries, all flags) for a mid-run reset.
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 1, 0, 6'h15, 3'd0, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h15, 3'd1, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 1, 0, 0, 6'h15, 3'd2, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 1, 6'h3F, 0, 0, 0, 6'h3F, 3'd2, 1);
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 0, 0, 6'h3F, 3'd2, 1);
    @(negedge iClk);
    @(negedge iClk);
    #2 iRst_n = 1'b0;
    queueAsync(6'h00, 3'd0, 1'b0);
    @(negedge iClk);
    #1 iRst_n = 1'b1;
    applyStimulus(0, 6'h00, 13'h0000, 0, 0, 6'h00, 0, 0, 0, 6'h00, 3'd0, 0);

    repeat (3) @(posedge iClk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL leftover: got %0d pending expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
